// File: rtl/scan_bus_bridge_pkg.sv
// Shared types and helpers for the scan-command-to-bus bridge.
package scan_bus_bridge_pkg;

  // Response error codes returned to the scan chain.
  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_e;

  // Bridge sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_REQ    = 3'd2,
    ST_GAP    = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Width of a target select field; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_addr_decode.sv
// Splits a global command address into target select, local address and
// a decode-error flag. Purely combinational.
module scan_addr_decode
  import scan_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int TGT_AW = 11,
  parameter int N_TGT  = 4,
  parameter int SEL_W  = sel_w(N_TGT)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic [TGT_AW-1:0] local_addr_o,
  output logic              dec_err_o
);

  localparam logic [SEL_W:0] NTGT_L = (SEL_W + 1)'(N_TGT);

  logic midNonZero;

  assign sel_o        = addr_i[ADDR_W-1 -: SEL_W];
  assign local_addr_o = addr_i[TGT_AW-1:0];

  // OR together the bits between the select field and the local address;
  // any of them set means the address falls in an unmapped hole.
  always_comb begin
    midNonZero = 1'b0;
    for (int i = TGT_AW; i < ADDR_W - SEL_W; i++) begin
      midNonZero = midNonZero | addr_i[i];
    end
  end

  assign dec_err_o = midNonZero | ({1'b0, sel_o} >= NTGT_L);

endmodule

// File: rtl/scan_bus_bridge.sv
// Scan-command-to-bus bridge: accepts one command per scan load, runs a
// single access, fill-write burst or checksum-read burst on one of N_TGT
// ready-handshaked targets, and returns a response word with error code.
module scan_bus_bridge
  import scan_bus_bridge_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int N_TGT   = 4,
  parameter int TGT_AW  = 11,
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic                    cmd_wen,
  input  logic                    cmd_ren,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [DATA_W-1:0]       cmd_wdata,
  input  logic [BURST_W-1:0]      cmd_len,
  output logic                    cmd_busy,
  output logic                    cmd_ovf,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [N_TGT-1:0]        tgt_ren,
  output logic [N_TGT-1:0]        tgt_wen,
  output logic [TGT_AW-1:0]       tgt_addr,
  output logic [DATA_W-1:0]       tgt_wdata,
  input  logic [N_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [N_TGT-1:0]        tgt_ready
);

  localparam int SEL_W = sel_w(N_TGT);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 wen_q, wen_d;
  logic                 ren_q, ren_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BURST_W-1:0]   left_q, left_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [TGT_AW-1:0]    addr_q, addr_d;
  err_e                 err_q, err_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [DATA_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  err_e                 rsperr_q, rsperr_d;
  logic                 ovf_q, ovf_d;

  logic [SEL_W-1:0]     decSel;
  logic [TGT_AW-1:0]    decLocal;
  logic                 decErr;
  logic [DATA_W-1:0]    rdataSel;
  logic                 readySel;
  logic [DATA_W-1:0]    beatSum;

  scan_addr_decode #(
    .ADDR_W (ADDR_W),
    .TGT_AW (TGT_AW),
    .N_TGT  (N_TGT),
    .SEL_W  (SEL_W)
  ) u_decode (
    .addr_i       (cmd_addr),
    .sel_o        (decSel),
    .local_addr_o (decLocal),
    .dec_err_o    (decErr)
  );

  // Pick the ready and read data of the captured target only.
  always_comb begin
    rdataSel = '0;
    readySel = 1'b0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel_q == SEL_W'(i)) begin
        rdataSel = tgt_rdata[i*DATA_W +: DATA_W];
        readySel = tgt_ready[i];
      end
    end
  end

  assign beatSum = sum_q + rdataSel;

  // Next-state logic: command capture, beat sequencing, timeout and checksum.
  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    ren_d    = ren_q;
    wdata_d  = wdata_q;
    left_d   = left_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    err_d    = err_q;
    to_d     = to_q;
    sum_d    = sum_q;
    rdata_d  = rdata_q;
    rsperr_d = rsperr_q;
    ovf_d    = ovf_q | (cmd_valid & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          wen_d   = cmd_wen;
          ren_d   = cmd_ren;
          wdata_d = cmd_wdata;
          left_d  = cmd_len;
          sel_d   = decSel;
          addr_d  = decLocal;
          sum_d   = '0;
          if (cmd_wen == cmd_ren) begin
            err_d = ERR_ILLEGAL;
          end else if (decErr) begin
            err_d = ERR_DECODE;
          end else begin
            err_d = ERR_OK;
          end
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        to_d = '0;
        if (err_q != ERR_OK) begin
          rsperr_d = err_q;
          rdata_d  = '0;
          state_d  = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (readySel) begin
          if (ren_q) begin
            sum_d = beatSum;
          end
          if (left_q == '0) begin
            rsperr_d = ERR_OK;
            rdata_d  = ren_q ? beatSum : '0;
            state_d  = ST_RESP;
          end else begin
            left_d  = left_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = ST_GAP;
          end
        end else if (to_q == TO_LAST) begin
          rsperr_d = ERR_TIMEOUT;
          rdata_d  = ren_q ? sum_q : '0;
          state_d  = ST_RESP;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      ST_GAP: begin
        to_d    = '0;
        state_d = ST_REQ;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      wdata_q  <= '0;
      left_q   <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      err_q    <= ERR_OK;
      to_q     <= '0;
      sum_q    <= '0;
      rdata_q  <= '0;
      rsperr_q <= ERR_OK;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      wdata_q  <= wdata_d;
      left_q   <= left_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      to_q     <= to_d;
      sum_q    <= sum_d;
      rdata_q  <= rdata_d;
      rsperr_q <= rsperr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Strobes are one-hot on the captured target, and only while in REQ.
  always_comb begin
    tgt_wen = '0;
    tgt_ren = '0;
    if (state_q == ST_REQ) begin
      for (int i = 0; i < N_TGT; i++) begin
        if (sel_q == SEL_W'(i)) begin
          tgt_wen[i] = wen_q;
          tgt_ren[i] = ren_q;
        end
      end
    end
  end

  assign tgt_addr  = addr_q;
  assign tgt_wdata = wdata_q;
  assign cmd_busy  = (state_q != ST_IDLE);
  assign cmd_ovf   = ovf_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsperr_q;

endmodule

// File: tb/tb_scan_bus_bridge.sv
// Randomised self-checking bench for scan_bus_bridge. A small target model
// answers strobes according to a per-beat wait plan, and a cycle-indexed
// expectation table derived from the command rules predicts every strobe,
// address, busy and response cycle.
module tb_scan_bus_bridge;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int N_TGT   = 4;
  localparam int TGT_AW  = 11;
  localparam int BURST_W = 4;
  localparam int TIMEOUT = 8;
  localparam int MAXC    = 256;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cmd_valid, cmd_wen, cmd_ren;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [DATA_W-1:0]       cmd_wdata;
  logic [BURST_W-1:0]      cmd_len;
  logic                    cmd_busy, cmd_ovf, rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [1:0]              rsp_err;
  logic [N_TGT-1:0]        tgt_ren, tgt_wen;
  logic [TGT_AW-1:0]       tgt_addr;
  logic [DATA_W-1:0]       tgt_wdata;
  logic [N_TGT*DATA_W-1:0] tgt_rdata;
  logic [N_TGT-1:0]        tgt_ready;

  int checkCount = 0;
  int errorCount = 0;
  logic ovfExp;

  int          planWait[16];
  logic [15:0] planData[16];
  logic        expOn[MAXC];
  logic [10:0] expAddr[MAXC];

  scan_bus_bridge #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .N_TGT   (N_TGT),
    .TGT_AW  (TGT_AW),
    .BURST_W (BURST_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_wen   (cmd_wen),
    .cmd_ren   (cmd_ren),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_len   (cmd_len),
    .cmd_busy  (cmd_busy),
    .cmd_ovf   (cmd_ovf),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .tgt_ren   (tgt_ren),
    .tgt_wen   (tgt_wen),
    .tgt_addr  (tgt_addr),
    .tgt_wdata (tgt_wdata),
    .tgt_rdata (tgt_rdata),
    .tgt_ready (tgt_ready)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Random noise on all target inputs; the strobed target is overridden.
  task automatic noiseTargets();
    tgt_ready = 4'($urandom);
    tgt_rdata = {$urandom, $urandom};
  endtask

  // Issue one command and follow it cycle by cycle until one cycle after
  // its response. injectMode 1/2 pulses a stray cmd_valid at T1 / in RESP.
  task automatic applyStimulus(input logic wen, input logic ren,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [3:0] len, input int injectMode);
    int          sel, mid, t, w, expRsp, injectAt, drvBeat, runLen;
    logic [1:0]  expErr;
    logic [15:0] expSum;
    logic [10:0] a;
    logic [3:0]  expW, expR, onVec;
    bit          readOk;

    sel = int'(addr[15:14]);
    mid = int'(addr[13:11]);
    a   = addr[10:0];
    for (int c = 0; c < MAXC; c++) begin
      expOn[c]   = 1'b0;
      expAddr[c] = '0;
    end
    expSum = '0;
    expRsp = 2;
    if (wen == ren) begin
      expErr = 2'd3;
    end else if (mid != 0 || sel >= N_TGT) begin
      expErr = 2'd1;
    end else begin
      expErr = 2'd0;
      t = 2;
      for (int k = 0; k <= int'(len); k++) begin
        w = planWait[k];
        if (w < 1 || w > TIMEOUT) begin
          for (int j = 0; j < TIMEOUT; j++) begin
            expOn[t+j]   = 1'b1;
            expAddr[t+j] = a;
          end
          expRsp = t + TIMEOUT;
          expErr = 2'd2;
          break;
        end
        for (int j = 0; j < w; j++) begin
          expOn[t+j]   = 1'b1;
          expAddr[t+j] = a;
        end
        expSum = expSum + planData[k];
        if (k == int'(len)) begin
          expRsp = t + w;
        end else begin
          t = t + w + 1;
          a = a + 11'd1;
        end
      end
    end
    readOk   = ren && !wen && (expErr == 2'd0 || expErr == 2'd2);
    injectAt = (injectMode == 1) ? 1 : (injectMode == 2) ? expRsp : -1;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wen   = wen;
    cmd_ren   = ren;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_len   = len;
    noiseTargets();
    drvBeat = 0;
    runLen  = 0;

    for (int c = 1; c <= expRsp + 1; c++) begin
      @(negedge clk);
      expW = (expOn[c] && wen) ? (4'b0001 << sel) : 4'b0000;
      expR = (expOn[c] && ren) ? (4'b0001 << sel) : 4'b0000;
      checkOutput($sformatf("cyc%0d valid/busy/wen/ren", c),
                  {54'd0, rsp_valid, cmd_busy, tgt_wen, tgt_ren},
                  {54'd0, (c == expRsp), (c <= expRsp), expW, expR});
      if (expOn[c]) begin
        checkOutput($sformatf("cyc%0d tgt_addr", c), 64'(tgt_addr), 64'(expAddr[c]));
        if (wen) checkOutput($sformatf("cyc%0d tgt_wdata", c), 64'(tgt_wdata), 64'(wdata));
      end
      if (c == expRsp) begin
        checkOutput("rsp_err", 64'(rsp_err), 64'(expErr));
        if (readOk) checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(expSum));
      end
      if (c == expRsp + 1) begin
        checkOutput("rsp_err held", 64'(rsp_err), 64'(expErr));
        if (readOk) checkOutput("rsp_rdata held", 64'(rsp_rdata), 64'(expSum));
      end

      // Drive inputs for this cycle: stray command pulse and target replies.
      cmd_valid = (c == injectAt);
      if (c == injectAt) begin
        ovfExp    = 1'b1;
        cmd_wen   = 1'($urandom);
        cmd_ren   = 1'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = 16'($urandom);
        cmd_len   = 4'($urandom);
      end
      noiseTargets();
      onVec = tgt_wen | tgt_ren;
      if (onVec != 4'b0000) begin
        runLen++;
        for (int i = 0; i < N_TGT; i++) begin
          if (onVec[i]) begin
            tgt_ready[i] = (runLen == planWait[drvBeat & 15]);
            tgt_rdata[i*DATA_W +: DATA_W] = planData[drvBeat & 15];
          end
        end
      end else if (runLen != 0) begin
        drvBeat++;
        runLen = 0;
      end
    end
    checkOutput("cmd_ovf", 64'(cmd_ovf), 64'(ovfExp));
    cmd_valid = 1'b0;
  endtask

  // Fill the beat plan with zero-wait beats carrying random read data.
  task automatic planZeroWait();
    for (int k = 0; k < 16; k++) begin
      planWait[k] = 1;
      planData[k] = 16'($urandom);
    end
  endtask

  // Reset asserted while beat 2 of a fill burst is on the bus.
  task automatic resetMidBurst();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wen   = 1'b1;
    cmd_ren   = 1'b0;
    cmd_addr  = 16'h0010;
    cmd_wdata = 16'h3C3C;
    cmd_len   = 4'd3;
    tgt_ready = 4'b0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst: beat2 strobe", 64'(tgt_wen), 64'(4'b0001));
    checkOutput("rst: beat2 addr", 64'(tgt_addr), 64'(11'h011));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst: outputs cleared",
                {8'd0, cmd_busy, cmd_ovf, rsp_valid, rsp_rdata, rsp_err,
                 tgt_ren, tgt_wen, tgt_addr, tgt_wdata}, 64'd0);
    rst    = 1'b0;
    ovfExp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tgt_ready = 4'b1111;
      @(negedge clk);
      checkOutput($sformatf("post-rst cyc%0d quiet", c),
                  {57'd0, rsp_valid, cmd_busy, tgt_wen | tgt_ren}, 64'd0);
    end
  endtask

  // Main sequence: reset, directed cases, random commands, reset mid-burst.
  initial begin
    int r, selR, midR, mode;
    logic [15:0] addrR;
    logic wenR, renR;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wen   = 1'b0;
    cmd_ren   = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_len   = '0;
    tgt_ready = '0;
    tgt_rdata = '0;
    ovfExp    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs",
                {8'd0, cmd_busy, cmd_ovf, rsp_valid, rsp_rdata, rsp_err,
                 tgt_ren, tgt_wen, tgt_addr, tgt_wdata}, 64'd0);
    rst = 1'b0;

    planZeroWait();
    applyStimulus(1'b1, 1'b0, 16'h0123, 16'hBEEF, 4'd0, 0);

    planZeroWait();
    planWait[0] = 3;
    planData[0] = 16'h1234;
    applyStimulus(1'b0, 1'b1, 16'h4005, 16'h0000, 4'd0, 0);

    planZeroWait();
    applyStimulus(1'b1, 1'b0, 16'h07FE, 16'h00AA, 4'd3, 0);

    planZeroWait();
    planData[0] = 16'hFFFF;
    planData[1] = 16'h0002;
    applyStimulus(1'b0, 1'b1, 16'h8010, 16'h0000, 4'd1, 0);

    planZeroWait();
    applyStimulus(1'b1, 1'b0, 16'h0800, 16'h1111, 4'd0, 0);
    applyStimulus(1'b1, 1'b1, 16'h0001, 16'h2222, 4'd0, 0);
    planWait[0] = 0;
    applyStimulus(1'b1, 1'b0, 16'hC001, 16'h3333, 4'd0, 0);

    planZeroWait();
    planWait[2] = 0;
    applyStimulus(1'b0, 1'b1, 16'h47FF, 16'h0000, 4'd2, 0);

    planZeroWait();
    planWait[0] = TIMEOUT;
    applyStimulus(1'b0, 1'b1, 16'hC100, 16'h0000, 4'd0, 0);

    planZeroWait();
    planWait[0] = 2;
    applyStimulus(1'b1, 1'b0, 16'h4100, 16'h5555, 4'd0, 1);
    applyStimulus(1'b0, 1'b1, 16'h8200, 16'h0000, 4'd0, 2);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 16; k++) begin
        r = $urandom_range(0, 19);
        planWait[k] = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 3
                    : $urandom_range(1, 4);
        planData[k] = 16'($urandom);
      end
      selR  = $urandom_range(0, 3);
      midR  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
      addrR = {selR[1:0], midR[2:0], 11'($urandom)};
      r = $urandom_range(0, 9);
      if (r == 0) begin
        wenR = 1'b1; renR = 1'b1;
      end else if (r == 1) begin
        wenR = 1'b0; renR = 1'b0;
      end else begin
        wenR = 1'($urandom); renR = ~wenR;
      end
      mode = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      applyStimulus(wenR, renR, addrR, 16'($urandom), 4'($urandom), mode);
    end

    resetMidBurst();

    planZeroWait();
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/scan_bus_bridge.md
# scan_bus_bridge

Parametrised scan-command-to-bus bridge in the `clk` domain, the next-generation replacement for the fixed SRAM/control/status router behind the scan chain. It accepts one synchronised command per scan load and decodes its address onto `N_TGT` ready-handshaked targets. It adds three behaviours the previous router lacked: burst fill writes, checksum burst reads, and a per-beat ready timeout. It returns a response word with an error code for the scan chain to capture.

## Interface
Parameters:
- `DATA_W`, 16, data width of command, targets and response
- `ADDR_W`, 16, command address width
- `N_TGT`, 4, number of targets (≥2)
- `TGT_AW`, 11, target-local address width
- `BURST_W`, 4, width of `cmd_len` (beats − 1)
- `TIMEOUT`, 255, max cycles a beat waits for ready (≥1)

Ports:
- `clk  in  1` single clock
- `rst  in  1` reset; synchronous, active-high
- `cmd_valid  in  1` one-cycle command pulse (from the scan-id synchroniser)
- `cmd_wen  in  1` write command
- `cmd_ren  in  1` read command
- `cmd_addr  in  ADDR_W` global address
- `cmd_wdata  in  DATA_W` write/fill data
- `cmd_len  in  BURST_W` burst length minus one
- `cmd_busy  out  1` high from accept until response issued
- `cmd_ovf  out  1` sticky: a `cmd_valid` arrived while busy
- `rsp_valid  out  1` one-cycle response pulse
- `rsp_rdata  out  DATA_W` read data or checksum, held until next response
- `rsp_err  out  2` 0 OK, 1 decode, 2 timeout, 3 illegal; held until next response
- `tgt_ren  out  N_TGT` per-target read strobe
- `tgt_wen  out  N_TGT` per-target write strobe
- `tgt_addr  out  TGT_AW` shared target address
- `tgt_wdata  out  DATA_W` shared write data
- `tgt_rdata  in  N_TGT*DATA_W` flattened read data; target i is at `[i*DATA_W +: DATA_W]`
- `tgt_ready  in  N_TGT` per-target beat completion

## Operation
- Address decode, with `SEL_W = $clog2(N_TGT)`:
  - Target select is `cmd_addr[ADDR_W-1 -: SEL_W]`.
  - Local address is `cmd_addr[TGT_AW-1:0]`.
  - The bits between them must be zero.
  - Nonzero middle bits, or a select ≥ `N_TGT`, produce a decode error (1).
- Both or neither of `cmd_wen`/`cmd_ren` set produces an illegal error (3).
- A decode or illegal error issues no strobe.
- State machine:
  - IDLE → DECODE on `cmd_valid`; all command fields are captured on this edge.
  - DECODE → RESP on error; otherwise DECODE → REQ.
  - REQ → GAP on ready when beats remain.
  - REQ → RESP on ready for the last beat.
  - REQ → RESP on timeout.
  - GAP → REQ after exactly one cycle.
  - RESP → IDLE after one cycle.
- In REQ:
  - Exactly one bit of `tgt_ren` or `tgt_wen` is high.
  - `tgt_addr` and `tgt_wdata` are stable.
  - All strobes are low in every other state.
- `tgt_ready` is sampled only in REQ and only for the selected target. Ready seen in any other state, or from other targets, is ignored.
- Write burst (fill): `cmd_len+1` beats, all carrying `cmd_wdata`.
- Read burst: `rsp_rdata` is the sum of all beats, wrapping modulo 2^DATA_W. For `cmd_len=0` this is the plain read data.
- `tgt_addr` increments by 1 per beat and wraps modulo 2^TGT_AW. Wrapping is not an error.
- Timeout:
  - A counter is cleared on entry to REQ.
  - If `TIMEOUT` REQ cycles pass without ready, the strobe drops and `rsp_err` is 2.
  - Remaining beats are abandoned.
  - On a read timeout, `rsp_rdata` is the partial sum.
- `cmd_valid` outside IDLE is dropped and sets `cmd_ovf`; only `rst` clears it.
- `cmd_valid` in the same cycle as the RESP→IDLE transition is dropped and counts as busy.

## Timing
- Reset values: all outputs 0 and state IDLE.
- `rst` asserted mid-operation forces all strobes low at that edge. A partial burst is never resumed.
- Single beat with ready at first REQ cycle, `cmd_valid` at T0:
  - T1 DECODE
  - T2 REQ (strobe high)
  - T3 RESP (`rsp_valid`)
  - T4 IDLE
- With ready in cycle w of REQ (w=1 is first), `rsp_valid` is at T2+w.
- Zero-wait burst: beat k strobe is at T2+2k; `rsp_valid` is at T3+2·cmd_len.
- Error response: `rsp_valid` at T2.
- `cmd_busy` is high T1 through RESP inclusive.
- `rsp_rdata`/`rsp_err` update on the edge entering RESP.

## Structure
- Package `scan_bus_bridge_pkg`:
  - `err_e` enum (OK, DECODE, TIMEOUT, ILLEGAL)
  - `state_e` enum (IDLE, DECODE, REQ, GAP, RESP)
  - function `sel_w(n)`
- One sub-module, `scan_addr_decode`: combinational decode of address into select, local address and decode-error.
- The FSM, beat counter, timeout counter and checksum accumulator live in the top.

## Test plan
Defaults: bits [15:14] select, [13:11] zero, [10:0] local.
1. Write to `0x0123`, data `0xBEEF`, tgt0 ready immediately → `tgt_wen[0]` high only at T2 with `tgt_addr=0x123`, `tgt_wdata=0xBEEF`; `rsp_valid` at T3, `rsp_err=0`.
2. Read `0x4005`, tgt1 ready in REQ cycle 3 with rdata `0x1234` → `tgt_ren[1]` high 3 cycles; `rsp_rdata=0x1234` at T5.
3. Fill: addr `0x07FE`, `cmd_len=3`, data `0x00AA` → four tgt0 wen pulses at addr 0x7FE, 0x7FF, 0x000, 0x001, one gap cycle apart; `rsp_err=0`.
4. Checksum read: `cmd_len=1`, beats `0xFFFF` then `0x0002` → `rsp_rdata=0x0001`.
5. Errors:
   - `0x0800` → `rsp_err=1`, no strobe, `rsp_valid` at T2.
   - `cmd_wen=cmd_ren=1` → `rsp_err=3`.
   - `TIMEOUT=8`, ready never asserted → strobe exactly 8 cycles, `rsp_err=2`.
6. `cmd_valid` at T1 of a busy command → ignored, `cmd_ovf=1` stays set. Separately, `rst` during beat 2 of a burst → strobes low at that edge, outputs 0, no `rsp_valid`.
